axi_lite_cmd_master: RTL and testbench

- AXI4-Lite master that feeds the SPI register slave `axi_spi_if` directly upstream of it.
- Accepts one simple command at a time (read or write, address, data, strobe) on a valid/ready port and drives the AW/W/B or AR/R channels.
- Returns the response on a valid/ready response port, including a per-transaction latency count.
- Used by the system sequencer and by benches to program SPI control, transfer and data registers.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_cmd_master.sv | 158 +++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, command-master FSM encoding, default bus widths.
package axi_lite_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RSP
    } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out (with latency count).
// Valids appear the cycle after acceptance; the response is held until rsp_ready_i, and no new command is taken until then.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16,
    parameter int PROT_W = 3
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [3:0]        cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_write_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,
    output logic [CNT_W-1:0]  rsp_cycles_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awprot_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        wstrb_o,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [PROT_W-1:0] arprot_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              aw_done;
    logic              w_done;
    logic              aw_fin;
    logic              w_fin;
    logic              busy;

    // A channel counts as finished once it has handshaken, now or earlier; it is never re-issued.
    assign aw_fin = aw_done | (awvalid_o & awready_i);
    assign w_fin  = w_done  | (wvalid_o & wready_i);
    assign busy   = state inside {ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R};

    assign awaddr_o     = addr_q;
    assign araddr_o     = addr_q;
    assign awprot_o     = 1'b0;
    assign arprot_o     = '0;
    assign rsp_cycles_o = cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b1;
            addr_q      <= '0;
            wdata_o     <= '0;
            wstrb_o     <= '0;
            cnt_q       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            awvalid_o   <= 1'b0;
            wvalid_o    <= 1'b0;
            bready_o    <= 1'b0;
            arvalid_o   <= 1'b0;
            rready_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_write_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_resp_o  <= '0;
        end else begin
            if (busy && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        wdata_o     <= cmd_wdata_i;
                        wstrb_o     <= cmd_wstrb_i;
                        cnt_q       <= '0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (cmd_write_i) begin
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                            state     <= ST_WR_AW_W;
                        end else begin
                            arvalid_o <= 1'b1;
                            state     <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (awvalid_o && awready_i) awvalid_o <= 1'b0;
                    if (wvalid_o && wready_i)   wvalid_o  <= 1'b0;
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) begin
                        bready_o <= 1'b1;
                        state    <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (bvalid_i) begin
                        bready_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_write_o <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_resp_o  <= bresp_i;
                        state       <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (rvalid_i) begin
                        rready_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_write_o <= 1'b0;
                        rsp_rdata_o <= rdata_i;
                        rsp_resp_o  <= rresp_i;
                        state       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed commands against a configurable AXI-Lite slave model,
// expected responses queued at issue time and checked by an independent response monitor.
module tb_axi_lite_cmd_master;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int PROT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_write;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [CNT_W-1:0]  rsp_cycles;
    logic              awvalid, wvalid, bready, arvalid, rready, awprot;
    logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata = '0;
    logic [3:0]        wstrb;
    logic [1:0]        bresp = 2'b00, rresp = 2'b00;
    logic [PROT_W-1:0] arprot;

    axi_lite_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .PROT_W(PROT_W)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
        .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp), .rsp_cycles_o(rsp_cycles),
        .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awprot_o(awprot),
        .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata), .wstrb_o(wstrb),
        .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp),
        .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arprot_o(arprot),
        .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [3:0]  cycles;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model configuration (written by the stimulus thread only)
    int          aw_wait = 0, w_wait = 0, b_dly = 0, ar_wait = 0, r_dly = 0, rsp_hold = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0, exp_wdata = '0;
    logic [27:0] exp_addr = '0;
    logic [3:0]  exp_wstrb = '0;

    // Slave model state and observation counters (written by the slave process only)
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int av_cyc = 0, wv_cyc = 0, br_cyc = 0, rr_cyc = 0;
    bit aw_d = 0, w_d = 0, b_arm = 0, b_fire = 0, r_arm = 0, r_fire = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_d = 0; w_d = 0; b_arm = 0; b_fire = 0; r_arm = 0; r_fire = 0;
        end else begin
            av_cyc += int'(awvalid);
            wv_cyc += int'(wvalid);
            br_cyc += int'(bready);
            rr_cyc += int'(rready);
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (b_arm) begin
                if (b_cnt >= b_dly) begin
                    bvalid = 1; bresp = bresp_cfg;
                    if (bready) begin b_hs++; b_arm = 0; b_fire = 1; end
                end else b_cnt++;
            end
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (r_arm) begin
                if (r_cnt >= r_dly) begin
                    rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg;
                    if (rready) begin r_hs++; r_arm = 0; r_fire = 1; end
                end else r_cnt++;
            end
            awready = 0;
            if (awvalid) begin
                if (aw_cnt >= aw_wait) begin
                    awready = 1; aw_hs++; aw_cnt = 0; aw_d = 1;
                    chk("awaddr", awaddr, exp_addr);
                    chk("awprot", awprot, 0);
                end else aw_cnt++;
            end
            wready = 0;
            if (wvalid) begin
                if (w_cnt >= w_wait) begin
                    wready = 1; w_hs++; w_cnt = 0; w_d = 1;
                    chk("wdata", wdata, exp_wdata);
                    chk("wstrb", wstrb, exp_wstrb);
                end else w_cnt++;
            end
            if (aw_d && w_d) begin aw_d = 0; w_d = 0; b_arm = 1; b_cnt = 0; end
            arready = 0;
            if (arvalid) begin
                if (ar_cnt >= ar_wait) begin
                    arready = 1; ar_hs++; ar_cnt = 0; r_arm = 1; r_cnt = 0;
                    chk("araddr", araddr, exp_addr);
                    chk("arprot", arprot, 0);
                end else ar_cnt++;
            end
        end
    end

    // Response monitor: holds off rsp_ready for rsp_hold cycles, then consumes and compares.
    int hold_cnt = 0;
    always @(negedge clk) begin : mon
        rsp_t e;
        if (!reset_n) begin
            rsp_ready = 0; hold_cnt = 0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response at %0t", $time);
                rsp_ready = 1;
            end else begin
                e = exp_q[0];
                chk("cmd_ready_in_rsp", cmd_ready, 0);
                if (hold_cnt < rsp_hold) begin
                    rsp_ready = 0; hold_cnt++;
                    chk("stall_write", rsp_write, e.wr);
                    chk("stall_rdata", rsp_rdata, e.rdata);
                    chk("stall_resp", rsp_resp, e.resp);
                    chk("stall_cycles", rsp_cycles, e.cycles);
                end else begin
                    rsp_ready = 1; hold_cnt = 0;
                    void'(exp_q.pop_front());
                    chk("rsp_write", rsp_write, e.wr);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", rsp_resp, e.resp);
                    chk("rsp_cycles", rsp_cycles, e.cycles);
                end
            end
        end else begin
            rsp_ready = 0;
        end
    end

    function automatic logic [3:0] sat(input int v);
        logic [31:0] t;
        t = v;
        return (v > 15) ? 4'hF : t[3:0];
    endfunction

    task automatic issue(input bit wr, input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1");
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got %0d pending responses, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
        chk("cmd_ready_after_rsp", cmd_ready, 1);
        chk("rsp_valid_after_rsp", rsp_valid, 0);
    endtask

    task automatic write_txn(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aww, input int ww, input int bd, input logic [1:0] resp,
                             input int hold);
        int aw0, w0, b0, av0, wv0, br0, rr0;
        rsp_t e;
        aw_wait = aww; w_wait = ww; b_dly = bd; bresp_cfg = resp; rsp_hold = hold;
        exp_addr = a; exp_wdata = d; exp_wstrb = s;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; av0 = av_cyc; wv0 = wv_cyc; br0 = br_cyc; rr0 = rr_cyc;
        e.wr = 1; e.rdata = '0; e.resp = resp; e.cycles = sat(2 + ((aww > ww) ? aww : ww) + bd);
        exp_q.push_back(e);
        issue(1, a, d, s);
        wait_done();
        chk("aw_handshakes", aw_hs - aw0, 1);
        chk("w_handshakes", w_hs - w0, 1);
        chk("b_handshakes", b_hs - b0, 1);
        chk("awvalid_cycles", av_cyc - av0, aww + 1);
        chk("wvalid_cycles", wv_cyc - wv0, ww + 1);
        chk("bready_cycles", br_cyc - br0, bd + 1);
        chk("rready_in_write", rr_cyc - rr0, 0);
        rsp_hold = 0;
    endtask

    task automatic read_txn(input logic [27:0] a, input int arw, input int rd,
                            input logic [31:0] d, input logic [1:0] resp);
        int ar0, r0, rr0, br0;
        rsp_t e;
        ar_wait = arw; r_dly = rd; rdata_cfg = d; rresp_cfg = resp; exp_addr = a;
        ar0 = ar_hs; r0 = r_hs; rr0 = rr_cyc; br0 = br_cyc;
        e.wr = 0; e.rdata = d; e.resp = resp; e.cycles = sat(2 + arw + rd);
        exp_q.push_back(e);
        issue(0, a, 32'h0, 4'h0);
        wait_done();
        chk("ar_handshakes", ar_hs - ar0, 1);
        chk("r_handshakes", r_hs - r0, 1);
        chk("rready_cycles", rr_cyc - rr0, rd + 1);
        chk("bready_in_read", br_cyc - br0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("rst_rsp_fields", {rsp_write, rsp_rdata, rsp_resp, rsp_cycles}, 0);
        chk("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 0);
        @(negedge clk);
        reset_n = 1;

        write_txn(28'h0, 32'h0000_0602, 4'hF, 0, 0, 0, 2'b00, 0);
        write_txn(28'h1, 32'h0000_0002, 4'hF, 3, 0, 0, 2'b00, 0);
        read_txn(28'h3, 0, 4, 32'h0000_0073, 2'b00);
        write_txn(28'h4, 32'h0000_00A5, 4'h3, 1, 1, 1, 2'b10, 5);

        // Reset while AW is stalled: valids must drop at once and no response may follow.
        aw_wait = 100; w_wait = 100; exp_addr = 28'h9; exp_wdata = 32'h1; exp_wstrb = 4'hF;
        issue(1, 28'h9, 32'h1, 4'hF);
        @(negedge clk);
        chk("pre_reset_awvalid", awvalid, 1);
        #2 reset_n = 0;
        #1;
        chk("async_rst_awvalid", awvalid, 0);
        chk("async_rst_wvalid", wvalid, 0);
        chk("async_rst_cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (8) @(negedge clk);
        chk("no_rsp_after_reset", rsp_valid, 0);
        chk("idle_after_reset", cmd_ready, 1);

        read_txn(28'h5, 0, 20, 32'hDEAD_BEEF, 2'b11);
        write_txn(28'hABC_DEF0, 32'h1234_5678, 4'h0, 0, 2, 2, 2'b11, 0);
        read_txn(28'h7, 2, 0, 32'h0000_1111, 2'b01);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
